// File: rtl/div_32_pkg.sv
// Shared definitions for the sequential signed divider: default width and FSM state encodings.
package div_32_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_CALC = 2'd1;
  localparam logic [1:0] DIV_FIX  = 2'd2;

endpackage

// File: rtl/div_32_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  // One extra bit so the shifted remainder never overflows the compare/subtract.
  logic [WIDTH:0] shifted;
  logic           ge;

  always_comb begin
    shifted = {rem_in, quo_in[WIDTH-1]};
    ge      = shifted >= {1'b0, divisor};
    rem_out = ge ? WIDTH'(shifted - {1'b0, divisor}) : shifted[WIDTH-1:0];
    quo_out = {quo_in[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/div_32.sv
// Sequential signed divider: magnitude restoring loop, one quotient bit per clock, then a sign fix.
module div_32
  import div_32_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   operand_x,
  input  logic [WIDTH-1:0]   operand_y,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic [2*WIDTH-1:0] out
);

  localparam int unsigned    CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_out_q, dbz_out_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;

  logic [WIDTH-1:0] abs_x, abs_y;
  logic [WIDTH-1:0] step_rem, step_quo;

  assign abs_x = operand_x[WIDTH-1] ? -operand_x : operand_x;
  assign abs_y = operand_y[WIDTH-1] ? -operand_y : operand_y;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in (rem_q),
    .quo_in (quo_q),
    .divisor(dvsr_q),
    .rem_out(step_rem),
    .quo_out(step_quo)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    dbz_d       = dbz_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    dbz_out_d   = dbz_out_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    case (state_q)
      DIV_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (operand_y != '0) begin
            rem_d     = '0;
            quo_d     = abs_x;
            dvsr_d    = abs_y;
            neg_quo_d = operand_x[WIDTH-1] ^ operand_y[WIDTH-1];
            neg_rem_d = operand_x[WIDTH-1];
            dbz_d     = 1'b0;
            count_d   = '0;
            state_d   = DIV_CALC;
          end else begin
            // The idle quotient register carries the raw dividend through to the fix cycle.
            quo_d   = operand_x;
            dbz_d   = 1'b1;
            state_d = DIV_FIX;
          end
        end
      end
      DIV_CALC: begin
        rem_d   = step_rem;
        quo_d   = step_quo;
        count_d = count_q + 1'b1;
        if (count_q == LastCnt) begin
          state_d = DIV_FIX;
        end
      end
      DIV_FIX: begin
        done_d    = 1'b1;
        busy_d    = 1'b0;
        dbz_out_d = dbz_q;
        if (dbz_q) begin
          quotient_d  = '1;
          remainder_d = quo_q;
        end else begin
          quotient_d  = neg_quo_q ? -quo_q : quo_q;
          remainder_d = neg_rem_q ? -rem_q : rem_q;
        end
        state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q     <= DIV_IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_out_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dbz_out_q   <= dbz_out_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_out_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign out         = {remainder_q, quotient_q};

endmodule

// File: tb/tb_div_32.sv
// Bench for div_32: 64-bit arithmetic reference model checked every cycle, plus literal pins.
module tb_div_32;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          clr_n;
  logic          start;
  logic [W-1:0]  operand_x, operand_y;
  logic          busy, done, div_by_zero;
  logic [W-1:0]  quotient, remainder;
  logic [2*W-1:0] out;

  always #5 clk = ~clk;

  div_32 #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .start      (start),
    .operand_x  (operand_x),
    .operand_y  (operand_y),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .quotient   (quotient),
    .remainder  (remainder),
    .out        (out)
  );

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    int           done_cyc;
  } txn_t;

  txn_t         exp_q[$];
  int           cyc = 0;
  int           last_done = 0;
  int           n_pass = 0;
  int           n_total = 0;
  bit           mon_en = 1'b0;
  logic [W-1:0] hold_q, hold_r;
  logic         hold_dbz;

  logic         m_done;
  logic [W-1:0] m_q, m_r;
  logic         m_dbz;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] got, logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, want %h (cycle %0d)", name, got, want, cyc);
  endfunction

  // Reference: exact signed division in 64 bits, truncated back to W bits.
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic dbz);
    longint lx, ly;
    if (y == '0) begin
      q   = '1;
      r   = x;
      dbz = 1'b1;
    end else begin
      lx  = longint'($signed(x));
      ly  = longint'($signed(y));
      q   = W'(lx / ly);
      r   = W'(lx % ly);
      dbz = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      m_done = 1'b0;
      if (exp_q.size() != 0 && cyc >= exp_q[0].done_cyc) begin
        model(exp_q[0].x, exp_q[0].y, m_q, m_r, m_dbz);
        hold_q   = m_q;
        hold_r   = m_r;
        hold_dbz = m_dbz;
        m_done   = 1'b1;
        void'(exp_q.pop_front());
      end
      check("mon_done", 64'(done), 64'(m_done));
      check("mon_busy", 64'(busy), 64'(exp_q.size() != 0));
      check("mon_quotient", 64'(quotient), 64'(hold_q));
      check("mon_remainder", 64'(remainder), 64'(hold_r));
      check("mon_dbz", 64'(div_by_zero), 64'(hold_dbz));
      check("mon_out", out, {hold_r, hold_q});
    end
  end

  task automatic flush_model();
    exp_q.delete();
    hold_q    = '0;
    hold_r    = '0;
    hold_dbz  = 1'b0;
    last_done = 0;
  endtask

  // Called just after a falling edge; the request is sampled on the following rising edge.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input bit accept);
    txn_t t;
    start     = 1'b1;
    operand_x = x;
    operand_y = y;
    @(posedge clk);
    #1;
    start     = 1'b0;
    operand_x = $urandom;
    operand_y = $urandom;
    if (accept) begin
      t.x        = x;
      t.y        = y;
      t.done_cyc = cyc + ((y == '0) ? 1 : 33);
      last_done  = t.done_cyc;
      exp_q.push_back(t);
    end
  endtask

  // Returns on the falling edge of the cycle in which done must be high.
  task automatic wait_done();
    int guard = 0;
    while (cyc < last_done && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (cyc < last_done) check("wait_bound", 64'(cyc), 64'(last_done));
  endtask

  task automatic run(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic [W-1:0] qe, input logic [W-1:0] re, input logic dbze);
    issue(x, y, 1'b1);
    wait_done();
    check({name, "_done"}, 64'(done), 64'd1);
    check({name, "_q"}, 64'(quotient), 64'(qe));
    check({name, "_r"}, 64'(remainder), 64'(re));
    check({name, "_dbz"}, 64'(div_by_zero), 64'(dbze));
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int e0;
    logic [W-1:0] rx, ry;
    clr_n     = 1'b0;
    start     = 1'b0;
    operand_x = '0;
    operand_y = '0;
    repeat (2) @(posedge clk);
    #1;
    clr_n = 1'b1;
    flush_model();
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_out", out, 64'd0);

    // Basic case and its packed result.
    issue(32'd100, 32'd7, 1'b1);
    wait_done();
    check("c1_done", 64'(done), 64'd1);
    check("c1_out", out, 64'h00000002_0000000E);
    @(negedge clk);

    run("neg_pos", -32'sd100, 32'd7, -32'sd14, -32'sd2, 1'b0);
    run("pos_neg", 32'd100, -32'sd7, -32'sd14, 32'd2, 1'b0);
    run("neg_neg", -32'sd100, -32'sd7, 32'd14, -32'sd2, 1'b0);
    run("zero_num", 32'd0, 32'd5, 32'd0, 32'd0, 1'b0);
    run("min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    run("max_p1", 32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'd0, 1'b0);
    run("dbz", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    run("after_dbz", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

    // Start while busy is ignored; start in the done cycle is accepted.
    issue(32'd100, 32'd7, 1'b1);
    e0 = cyc;
    while (cyc < e0 + 9) @(negedge clk);
    issue(32'd50, 32'd5, 1'b0);
    wait_done();
    check("busy_start_q", 64'(quotient), 64'd14);
    check("busy_start_r", 64'(remainder), 64'd2);
    issue(32'd50, 32'd5, 1'b1);
    wait_done();
    check("done_cycle_start_q", 64'(quotient), 64'd10);
    @(negedge clk);

    // Reset mid-operation abandons the division.
    issue(32'd100, 32'd7, 1'b1);
    e0 = cyc;
    while (cyc < e0 + 14) @(negedge clk);
    clr_n = 1'b0;
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    flush_model();
    repeat (40) @(negedge clk);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_out", out, 64'd0);
    run("after_rst", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

    // Random sweep, mixing in zero, -1, small and most-negative operands.
    for (int i = 0; i < 1000; i++) begin
      rx = $urandom;
      ry = $urandom;
      if (i % 40 == 0) ry = '0;
      else if (i % 10 == 1) ry = 32'($urandom_range(1, 15));
      else if (i % 10 == 2) ry = 32'hFFFF_FFFF;
      else if (i % 10 == 3) ry = -32'($urandom_range(1, 300));
      if (i % 17 == 0) rx = 32'h8000_0000;
      issue(rx, ry, 1'b1);
      wait_done();
      if (i % 2 == 0) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
